// File: rtl/main_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32 main controller.
// No ports: state enum, opcodes, imm formats and datapath select codes.
package main_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD,
    MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR,
    JALRWB, LUI, AUIPC, TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_OLDPC = 2'b01;
  localparam logic [1:0] SA_RS1   = 2'b10;
  localparam logic [1:0] SA_ZERO  = 2'b11;

  localparam logic [1:0] SB_RS2  = 2'b00;
  localparam logic [1:0] SB_IMM  = 2'b01;
  localparam logic [1:0] SB_FOUR = 2'b10;

  localparam logic [1:0] RS_ALUOUT = 2'b00;
  localparam logic [1:0] RS_DATA   = 2'b01;
  localparam logic [1:0] RS_ALURES = 2'b10;

  localparam logic [1:0] AO_ADD  = 2'b00;
  localparam logic [1:0] AO_SUB  = 2'b01;
  localparam logic [1:0] AO_FUNC = 2'b10;

endpackage

// File: rtl/main_ctrl_fsm_if.sv
// Controller bundle: instruction fields and flags in, control strobes out.
// master drives op/funct3/zero/mem_ready; slave (controller) drives the rest.
interface main_ctrl_fsm_if #(
  parameter int IMM_SRC_W = 3
);
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 zero;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 adr_src;
  logic                 mem_write;
  logic                 ir_write;
  logic                 reg_write;
  logic                 branch;
  logic                 illegal;
  logic [1:0]           result_src;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic [IMM_SRC_W-1:0] imm_src;
  logic [3:0]           state_o;

  modport master (
    output op, funct3, zero, mem_ready,
    input  pc_write, adr_src, mem_write,
    input  ir_write, reg_write, branch,
    input  illegal, result_src, alu_src_a,
    input  alu_src_b, alu_op, imm_src,
    input  state_o
  );

  modport slave (
    input  op, funct3, zero, mem_ready,
    output pc_write, adr_src, mem_write,
    output ir_write, reg_write, branch,
    output illegal, result_src, alu_src_a,
    output alu_src_b, alu_op, imm_src,
    output state_o
  );
endinterface

// File: rtl/main_ctrl_fsm_imm_fmt_dec.sv
// Opcode -> immediate format decoder, purely combinational.
// Ports: op (7b) in, imm_src (IMM_SRC_W) out.
module imm_fmt_dec
  import main_ctrl_fsm_pkg::*;
#(
  parameter bit SUPPORT_U = 1'b1,
  parameter int IMM_SRC_W = 3
) (
  input  logic [6:0]           op,
  output logic [IMM_SRC_W-1:0] imm_src
);

  logic [2:0] fmt;

  always_comb begin
    fmt = IMM_I;
    unique case (op)
      OP_STORE:         fmt = IMM_S;
      OP_BR:            fmt = IMM_B;
      OP_JAL:           fmt = IMM_J;
      OP_LUI, OP_AUIPC: fmt = SUPPORT_U ? IMM_U : IMM_I;
      default:          fmt = IMM_I;
    endcase
  end

  assign imm_src = IMM_SRC_W'(fmt);

endmodule

// File: rtl/main_ctrl_fsm.sv
// Moore main controller for a multicycle RV32 datapath.
// Ports: clk, rst_n (async, active-low), bus (main_ctrl_fsm_if.slave).
module main_ctrl_fsm
  import main_ctrl_fsm_pkg::*;
#(
  parameter bit SUPPORT_U = 1'b1,
  parameter int IMM_SRC_W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  main_ctrl_fsm_if.slave bus
);

  state_e state_q, state_d;

  logic is_load, is_store, is_r, is_i;
  logic is_br, is_jal, is_jalr;
  logic is_lui, is_auipc;

  assign is_load  = bus.op == OP_LOAD;
  assign is_store = bus.op == OP_STORE;
  assign is_r     = bus.op == OP_R;
  assign is_i     = bus.op == OP_I;
  assign is_br    = bus.op == OP_BR;
  assign is_jal   = bus.op == OP_JAL;
  assign is_jalr  = bus.op == OP_JALR;
  assign is_lui   = SUPPORT_U && bus.op == OP_LUI;
  assign is_auipc = SUPPORT_U && bus.op == OP_AUIPC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:    if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_load, is_store: state_d = MEMADR;
          is_r:              state_d = EXECR;
          is_i:              state_d = EXECI;
          is_br:             state_d = BRANCH;
          is_jal:            state_d = JAL;
          is_jalr:           state_d = JALR;
          is_lui:            state_d = LUI;
          is_auipc:          state_d = AUIPC;
          default:           state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = is_store ? MEMWRITE : MEMREAD;
      MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (bus.mem_ready) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JAL:      state_d = ALUWB;
      JALR:     state_d = JALRWB;
      JALRWB:   state_d = FETCH;
      LUI:      state_d = ALUWB;
      AUIPC:    state_d = ALUWB;
      TRAP:     state_d = TRAP;
    endcase
  end

  logic       pc_w, mem_w, ir_w, reg_w, ill;
  logic       adr, br;
  logic [1:0] rs, sa, sb, ao;
  logic       br_take;

  assign br_take = (bus.funct3 == F3_BEQ &&  bus.zero)
                || (bus.funct3 == F3_BNE && !bus.zero);

  always_comb begin
    pc_w  = 1'b0;
    mem_w = 1'b0;
    ir_w  = 1'b0;
    reg_w = 1'b0;
    ill   = 1'b0;
    adr   = 1'b0;
    br    = 1'b0;
    rs    = RS_ALUOUT;
    sa    = SA_PC;
    sb    = SB_RS2;
    ao    = AO_ADD;
    unique case (state_q)
      FETCH: begin
        sb   = SB_FOUR;
        rs   = RS_ALURES;
        ir_w = bus.mem_ready;
        pc_w = bus.mem_ready;
      end
      DECODE: begin
        sa = SA_OLDPC;
        sb = SB_IMM;
      end
      MEMADR: begin
        sa = SA_RS1;
        sb = SB_IMM;
      end
      MEMREAD:  adr = 1'b1;
      MEMWB: begin
        rs    = RS_DATA;
        reg_w = 1'b1;
      end
      MEMWRITE: begin
        adr   = 1'b1;
        mem_w = 1'b1;
      end
      EXECR: begin
        sa = SA_RS1;
        ao = AO_FUNC;
      end
      EXECI: begin
        sa = SA_RS1;
        sb = SB_IMM;
        ao = AO_FUNC;
      end
      ALUWB:    reg_w = 1'b1;
      BRANCH: begin
        sa   = SA_RS1;
        ao   = AO_SUB;
        br   = 1'b1;
        pc_w = br_take;
      end
      JAL: begin
        sa   = SA_OLDPC;
        sb   = SB_FOUR;
        pc_w = 1'b1;
      end
      JALR: begin
        sa   = SA_RS1;
        sb   = SB_IMM;
        rs   = RS_ALURES;
        pc_w = 1'b1;
      end
      JALRWB: begin
        sa    = SA_OLDPC;
        sb    = SB_FOUR;
        rs    = RS_ALURES;
        reg_w = 1'b1;
      end
      LUI: begin
        sa = SA_ZERO;
        sb = SB_IMM;
      end
      AUIPC: begin
        sa = SA_OLDPC;
        sb = SB_IMM;
      end
      TRAP:     ill = 1'b1;
    endcase
  end

  // FETCH strobes follow mem_ready combinationally, so reset must
  // mask the enables directly rather than rely on the state alone.
  assign bus.pc_write   = pc_w  & rst_n;
  assign bus.mem_write  = mem_w & rst_n;
  assign bus.ir_write   = ir_w  & rst_n;
  assign bus.reg_write  = reg_w & rst_n;
  assign bus.illegal    = ill   & rst_n;
  assign bus.adr_src    = adr;
  assign bus.branch     = br;
  assign bus.result_src = rs;
  assign bus.alu_src_a  = sa;
  assign bus.alu_src_b  = sb;
  assign bus.alu_op     = ao;
  assign bus.state_o    = state_q;

  imm_fmt_dec #(
    .SUPPORT_U (SUPPORT_U),
    .IMM_SRC_W (IMM_SRC_W)
  ) u_imm (
    .op      (bus.op),
    .imm_src (bus.imm_src)
  );

endmodule

// File: doc/main_ctrl_fsm.md
MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

Interface
REQ-001 Parameter SUPPORT_U, default 1, meaning: LUI/AUIPC decoded when 1, illegal when 0.
REQ-002 Parameter IMM_SRC_W, default 3, meaning: imm_src width, minimum 3.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 op  input  7  opcode field of the instruction register.
REQ-006 funct3  input  3  funct3 field of the instruction register.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory access completes this cycle.
REQ-009 Outputs, all 1 bit: pc_write, adr_src, mem_write, ir_write, reg_write, branch, illegal.
REQ-010 Outputs, all 2 bits: result_src, alu_src_a, alu_src_b, alu_op.
REQ-011 imm_src  output  IMM_SRC_W  immediate format: 0 I, 1 S, 2 B, 3 J, 4 U.
REQ-012 state_o  output  4  current state encoding, for debug.

Function
REQ-013 Moore FSM: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALRWB, LUI, AUIPC, TRAP.
REQ-014 imm_src combinational from op in every state: 0000011/0010011/1100111 -> 0; 0100011 -> 1; 1100011 -> 2; 1101111 -> 3; 0110111/0010111 -> 4 (SUPPORT_U=1); else 0.
REQ-015 Outputs not listed for a state are 0.
REQ-016 FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, alu_op=00. ir_write=pc_write=mem_ready. Stay until mem_ready=1, then DECODE.
REQ-017 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00. Next by op: lw/sw -> MEMADR; R-type 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI and 0010111 -> AUIPC when SUPPORT_U=1; any other op -> TRAP.
REQ-018 MEMADR: alu_src_a=10, alu_src_b=01. Next: MEMREAD for op 0000011, MEMWRITE for op 0100011.
REQ-019 MEMREAD: adr_src=1, result_src=00. Stay until mem_ready, then MEMWB.
REQ-020 MEMWB: result_src=01, reg_write=1, then FETCH.
REQ-021 MEMWRITE: adr_src=1, result_src=00, mem_write=1 every cycle in the state. Stay until mem_ready, then FETCH.
REQ-022 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
REQ-023 EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
REQ-024 ALUWB: result_src=00, reg_write=1, then FETCH.
REQ-025 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1.
REQ-026 BRANCH pc_write = zero when funct3=000 (beq) and ~zero when funct3=001 (bne). Other funct3 values give pc_write=0. Next state FETCH.
REQ-027 JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_write=1, then ALUWB.
REQ-028 JALR: alu_src_a=10, alu_src_b=01, result_src=10, pc_write=1, then JALRWB.
REQ-029 JALRWB: alu_src_a=01, alu_src_b=10, result_src=10, reg_write=1, then FETCH.
REQ-030 LUI: alu_src_a=11 (zero operand), alu_src_b=01, then ALUWB.
REQ-031 AUIPC: alu_src_a=01, alu_src_b=01, then ALUWB.
REQ-032 TRAP: illegal=1. All write enables are 0. TRAP is absorbing until reset.
REQ-033 Latency when mem_ready is held at 1: R/I/LUI/AUIPC/JAL 4 cycles; lw 5; sw 4; branch 3; jalr 4.
REQ-034 mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE, and is ignored in all other states.

Reset
REQ-035 rst_n=0 forces state FETCH immediately, regardless of clk.
REQ-036 While rst_n=0, all write enables are 0 and illegal=0.
REQ-037 Reset asserted mid-instruction abandons that instruction. No pending write survives reset.
REQ-038 On the first clk edge after rst_n rises, the FSM evaluates FETCH normally.

Structure
REQ-039 A shared package holds: the state enum, the opcode constants, the imm_src format codes, and the alu_src_a/alu_src_b/result_src/alu_op encodings.
REQ-040 One sub-module, imm_fmt_dec, holds the combinational op -> imm_src mapping, parametrised by SUPPORT_U and IMM_SRC_W.

Verification
REQ-041 add: op=0110011, mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB; reg_write=1 only in cycle 4.
REQ-042 lw: op=0000011, mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, adr_src=1 throughout; MEMWB then has result_src=01 and reg_write=1.
REQ-043 bne: op=1100011, funct3=001, zero=0 -> pc_write=1 in BRANCH; repeat with zero=1 -> pc_write=0.
REQ-044 lui: op=0110111 with SUPPORT_U=0 -> TRAP with illegal=1 held for 10 cycles; with SUPPORT_U=1 -> LUI, ALUWB, and imm_src=4.
REQ-045 rst_n pulled low mid-clock while in MEMWRITE -> mem_write=0 immediately and state_o=FETCH before the next edge.
REQ-046 op=1111111 -> TRAP, and all write enables stay 0 until rst_n=0.
